// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and defaults for the clock-gate enable controller.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    IDLE = 2'd1,
    OFF  = 2'd2,
    WAKE = 2'd3
  } clk_gate_state_e;

  localparam int unsigned WAKE_CYCLES_DEF = 2;

endpackage

// File: rtl/clk_gate_stats_cnt.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module clk_gate_stats_cnt #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && !(&cnt_o)) begin
      cnt_o <= cnt_o + Width'(1);
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller with idle hysteresis and post-wake settle delay.
// Optional gated-cycle statistics counter enabled by CLK_GATE_CTRL_STATS_EN.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned CntWidth   = 8,
  parameter int unsigned WakeCycles = WAKE_CYCLES_DEF,
  parameter int unsigned StatsWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  busy_i,
  input  logic                  wake_i,
  input  logic                  force_on_i,
  input  logic [CntWidth-1:0]   idle_cycles_i,
  output logic                  clk_en_o,
  output logic                  ready_o,
  output logic                  gated_o,
  input  logic                  stats_clr_i,
  output logic [StatsWidth-1:0] gated_cycles_o
);

  localparam logic [CntWidth-1:0] WAKE_LAST = CntWidth'(WakeCycles - 1);

  if (64'(WakeCycles) >= (64'(1) << CntWidth)) begin : g_wake_range_err
    $error("clk_gate_ctrl: WakeCycles does not fit in CntWidth bits");
  end

  clk_gate_state_e     state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth:0]   cnt_plus1;
  logic [CntWidth-1:0] cnt_sat;
  logic                idle;
  logic                wake_req;

  assign wake_req  = wake_i || force_on_i;
  assign idle      = !busy_i && !wake_req;
  assign cnt_plus1 = {1'b0, cnt_q} + (CntWidth + 1)'(1);
  assign cnt_sat   = (&cnt_q) ? cnt_q : cnt_plus1[CntWidth-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        cnt_d = '0;
        if (idle && (idle_cycles_i != '0)) begin
          if (idle_cycles_i == CntWidth'(1)) begin
            state_d = OFF;
          end else begin
            state_d = IDLE;
            cnt_d   = CntWidth'(1);
          end
        end
      end
      IDLE: begin
        if (!idle || (idle_cycles_i == '0)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_plus1 >= {1'b0, idle_cycles_i}) begin
          state_d = OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      OFF: begin
        // busy_i is meaningless here: the domain has no clock to report with
        cnt_d = '0;
        if (wake_req) begin
          state_d = (WakeCycles == 0) ? RUN : WAKE;
        end
      end
      WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs registered from next state; reset keeps the clock running
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_en_o <= 1'b1;
      ready_o  <= 1'b1;
      gated_o  <= 1'b0;
    end else begin
      clk_en_o <= (state_d != OFF);
      ready_o  <= (state_d == RUN) || (state_d == IDLE);
      gated_o  <= (state_d == OFF);
    end
  end

`ifdef CLK_GATE_CTRL_STATS_EN
  clk_gate_stats_cnt #(
    .Width(StatsWidth)
  ) u_stats (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (stats_clr_i),
    .inc_i (gated_o),
    .cnt_o (gated_cycles_o)
  );
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr_i;
  assign gated_cycles_o   = '0;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_clk_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy = 1'b1;
  logic        wake = 1'b0;
  logic        force_on = 1'b0;
  logic [7:0]  idle_cycles = 8'd4;
  logic        stats_clr = 1'b0;

  logic        en   [2];
  logic        rdy  [2];
  logic        gtd  [2];
  logic [31:0] gcyc [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_gate_ctrl #(.CntWidth(8), .WakeCycles(2), .StatsWidth(32)) dut (
    .clk_i(clk), .rst_i(rst), .busy_i(busy), .wake_i(wake), .force_on_i(force_on),
    .idle_cycles_i(idle_cycles), .clk_en_o(en[0]), .ready_o(rdy[0]), .gated_o(gtd[0]),
    .stats_clr_i(stats_clr), .gated_cycles_o(gcyc[0])
  );

  clk_gate_ctrl #(.CntWidth(8), .WakeCycles(0), .StatsWidth(32)) dut0 (
    .clk_i(clk), .rst_i(rst), .busy_i(busy), .wake_i(wake), .force_on_i(force_on),
    .idle_cycles_i(idle_cycles), .clk_en_o(en[1]), .ready_o(rdy[1]), .gated_o(gtd[1]),
    .stats_clr_i(stats_clr), .gated_cycles_o(gcyc[1])
  );

  // Behavioural model: gated flag, settle countdown, consecutive-idle run length
  int     wake_cfg [2] = '{2, 0};
  bit     m_gated  [2] = '{0, 0};
  bit     m_en     [2] = '{1, 1};
  bit     m_rdy    [2] = '{1, 1};
  int     m_run    [2] = '{0, 0};
  int     m_left   [2] = '{0, 0};
  longint m_stats  [2] = '{0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_gated[i] = 0; m_en[i] = 1; m_rdy[i] = 1; m_run[i] = 0; m_left[i] = 0; m_stats[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (stats_clr) m_stats[i] = 0;
        else if (m_gated[i] && m_stats[i] < 64'hFFFF_FFFF) m_stats[i] = m_stats[i] + 1;
        if (m_gated[i]) begin
          if (wake || force_on) begin
            m_gated[i] = 0; m_en[i] = 1; m_left[i] = wake_cfg[i];
            m_rdy[i] = (wake_cfg[i] == 0);
          end
        end else if (!m_rdy[i]) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) m_rdy[i] = 1;
        end else if (!busy && !wake && !force_on && idle_cycles != 0) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= int'(idle_cycles)) begin
            m_gated[i] = 1; m_en[i] = 0; m_rdy[i] = 0; m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint exp_stats(input int i);
`ifdef CLK_GATE_CTRL_STATS_EN
    return m_stats[i];
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_clk_en[%0d]", i), 64'(en[i]), 64'(m_en[i]));
      chk($sformatf("model_ready[%0d]", i), 64'(rdy[i]), 64'(m_rdy[i]));
      chk($sformatf("model_gated[%0d]", i), 64'(gtd[i]), 64'(m_gated[i]));
      chk($sformatf("model_stats[%0d]", i), 64'(gcyc[i]), 64'(exp_stats(i)));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int i, input bit e_en, input bit e_rdy, input bit e_g);
    chk({name, "_clk_en"}, 64'(en[i]), 64'(e_en));
    chk({name, "_ready"}, 64'(rdy[i]), 64'(e_rdy));
    chk({name, "_gated"}, 64'(gtd[i]), 64'(e_g));
  endtask

`ifdef CLK_GATE_CTRL_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  initial begin
    repeat (3) cyc();
    lit("reset", 0, 1, 1, 0);
    chk("reset_stats", 64'(gcyc[0]), 64'd0);
    rst = 1'b0;
    cyc();

    // Gate timing with idle_cycles=4
    busy = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      lit($sformatf("gate_wait%0d", k), 0, 1, 1, 0);
    end
    cyc();
    lit("gate_off", 0, 0, 0, 1);
    lit("gate_off_w0", 1, 0, 0, 1);

    // Statistics while OFF
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    chk("stats_clr0", 64'(gcyc[0]), 64'd0);
    repeat (100) cyc();
    chk("stats_100", 64'(gcyc[0]), STATS_ON ? 64'd100 : 64'd0);
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    chk("stats_clr", 64'(gcyc[0]), 64'd0);
    cyc();
    chk("stats_resume", 64'(gcyc[0]), STATS_ON ? 64'd1 : 64'd0);

    // One-cycle wake pulse
    busy = 1'b1;
    wake = 1'b1;
    cyc();
    wake = 1'b0;
    lit("wake_c1", 0, 1, 0, 0);
    lit("wake0_c1", 1, 1, 1, 0);
    cyc();
    lit("wake_c2", 0, 1, 0, 0);
    cyc();
    lit("wake_c3", 0, 1, 1, 0);

    // Hysteresis abort then four fresh idle cycles
    busy = 1'b0;
    repeat (3) cyc();
    lit("abort_pre", 0, 1, 1, 0);
    busy = 1'b1;
    cyc();
    busy = 1'b0;
    repeat (3) cyc();
    lit("abort_3", 0, 1, 1, 0);
    cyc();
    lit("abort_4", 0, 0, 0, 1);

    // force_on_i wakes like wake_i
    busy = 1'b1;
    force_on = 1'b1;
    cyc();
    force_on = 1'b0;
    lit("force_c1", 0, 1, 0, 0);
    lit("force0_c1", 1, 1, 1, 0);
    repeat (2) cyc();
    lit("force_c3", 0, 1, 1, 0);

    // idle_cycles=0 never gates; idle_cycles=1 gates after one idle cycle
    idle_cycles = 8'd0;
    busy = 1'b0;
    repeat (50) cyc();
    lit("nogate", 0, 1, 1, 0);
    idle_cycles = 8'd1;
    cyc();
    lit("n1_gate", 0, 0, 0, 1);

    // Asynchronous reset from OFF
    #2;
    rst = 1'b1;
    #1;
    lit("async_rst", 0, 1, 1, 0);
    lit("async_rst_w0", 1, 1, 1, 0);
    cyc();
    rst = 1'b0;
    busy = 1'b1;
    cyc();
    lit("post_rst", 0, 1, 1, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 6))
          0: idle_cycles = 8'd0;
          1: idle_cycles = 8'd1;
          2: idle_cycles = 8'd2;
          3: idle_cycles = 8'd3;
          4: idle_cycles = 8'd4;
          5: idle_cycles = 8'd5;
          default: idle_cycles = 8'd8;
        endcase
      end
      busy      = ($urandom_range(0, 9) < 3);
      wake      = ($urandom_range(0, 14) == 0);
      force_on  = ($urandom_range(0, 29) == 0);
      stats_clr = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
